// File: rtl/led_blink_arbiter.sv
// ---------------------------------------------------------------------------
// led_blink_arbiter
//
// Purpose: share one status LED between NUM_REQ requesters. Each requester
// raises req[i] with a blink count on req_count[4i+3:4i]. The winner's count
// is latched at grant and played out as <count> blinks of BLINK_INTERVAL
// cycles on / BLINK_INTERVAL cycles off. A dark gap of
// GAP_INTERVALS*BLINK_INTERVAL cycles follows, then ack pulses for one cycle
// on the winner's bit.
//
// Ports:
//   clk        system clock, all state updates on its rising edge
//   rst        synchronous active-high reset; aborts any code without ack
//   req        per-requester request, held high until ack
//   req_count  per-requester blink count (4 bits each), sampled at grant only
//   grant      one-hot requester being served, zero when idle
//   ack        one-cycle pulse on the served requester's bit at code end
//   busy       high whenever the FSM is not idle
//   LED        shared LED drive, 1 = on
//
// Build option: define BLINK_RR_EN for round-robin arbitration starting after
// the last winner. Without it, arbitration is fixed priority (lowest index
// wins) and no pointer register is built.
//
// state | meaning
// IDLE  | waiting for a request; grant decided here
// ON    | LED lit for BLINK_INTERVAL cycles
// OFF   | LED dark for BLINK_INTERVAL cycles, count decremented on exit
// GAP   | LED dark for GAP_INTERVALS*BLINK_INTERVAL cycles, ack on exit
// ---------------------------------------------------------------------------
module led_blink_arbiter #(
  parameter int BLINK_INTERVAL = 6000000,
  parameter int GAP_INTERVALS  = 4,
  parameter int NUM_REQ        = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [4*NUM_REQ-1:0]   req_count,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   busy,
  output logic                   LED
);

  localparam int TLEN = GAP_INTERVALS * BLINK_INTERVAL;
  // Sized for the longest phase (the gap); ON/OFF reuse the same counter.
  localparam int TW   = (TLEN > 1) ? $clog2(TLEN) : 1;
  localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [TW-1:0] BLINK_TC = TW'(BLINK_INTERVAL - 1);
  localparam logic [TW-1:0] GAP_TC   = TW'(TLEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic                 led_nxt;
  logic [NUM_REQ-1:0]   grant_nxt;
  logic [NUM_REQ-1:0]   ack_nxt;
  logic [TW-1:0]        timer, timer_nxt;
  logic [3:0]           remaining, remaining_nxt;
  logic [3:0]           win_count;
  logic [PW-1:0]        win_idx;

`ifdef BLINK_RR_EN
  logic [PW-1:0]        ptr, ptr_nxt;
  logic [PW-1:0]        cand_idx;
  int                   cand;

  // Scan from the highest offset down so the lowest offset past the last
  // winner is the final (winning) assignment.
  always_comb begin
    win_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(ptr) + 1 + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = PW'(cand);
      if (req[cand_idx]) win_idx = cand_idx;
    end
  end
`else
  always_comb begin
    win_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) win_idx = PW'(k);
    end
  end
`endif

  assign win_count = req_count[{win_idx, 2'b00} +: 4];
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt     = state;
    led_nxt       = LED;
    grant_nxt     = grant;
    ack_nxt       = '0;
    timer_nxt     = timer + TW'(1);
    remaining_nxt = remaining;
`ifdef BLINK_RR_EN
    ptr_nxt       = ptr;
`endif
    case (state)
      IDLE: begin
        timer_nxt = '0;
        // A registered ack still high blocks the grant, forcing a quiet
        // cycle between consecutive codes.
        if ((ack == '0) && (req != '0)) begin
          grant_nxt     = NUM_REQ'(1) << win_idx;
          remaining_nxt = win_count;
`ifdef BLINK_RR_EN
          ptr_nxt       = win_idx;
`endif
          if (win_count != 4'd0) begin
            state_nxt = ON;
            led_nxt   = 1'b1;
          end else begin
            state_nxt = GAP;
          end
        end
      end
      ON: begin
        if (timer == BLINK_TC) begin
          state_nxt = OFF;
          led_nxt   = 1'b0;
          timer_nxt = '0;
        end
      end
      OFF: begin
        if (timer == BLINK_TC) begin
          remaining_nxt = remaining - 4'd1;
          timer_nxt     = '0;
          if (remaining != 4'd1) begin
            state_nxt = ON;
            led_nxt   = 1'b1;
          end else begin
            state_nxt = GAP;
          end
        end
      end
      GAP: begin
        if (timer == GAP_TC) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          ack_nxt   = grant;
          timer_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        led_nxt   = 1'b0;
        grant_nxt = '0;
        timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      LED       <= 1'b0;
      grant     <= '0;
      ack       <= '0;
      timer     <= '0;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      LED       <= led_nxt;
      grant     <= grant_nxt;
      ack       <= ack_nxt;
      timer     <= timer_nxt;
      remaining <= remaining_nxt;
    end
  end

`ifdef BLINK_RR_EN
  always_ff @(posedge clk) begin
    if (rst) ptr <= PW'(NUM_REQ - 1);
    else     ptr <= ptr_nxt;
  end
`endif

endmodule

// File: tb/tb_led_blink_arbiter.sv
// ---------------------------------------------------------------------------
// tb_led_blink_arbiter
//
// Directed bench for led_blink_arbiter with BLINK_INTERVAL=4,
// GAP_INTERVALS=2, NUM_REQ=4. Expected codes (grant, LED-high cycles,
// grant-to-ack latency) are pushed to a queue as requests are driven and
// popped when the DUT finishes a code. Expectations for the RR scenario
// follow BLINK_RR_EN.
// ---------------------------------------------------------------------------
module tb_led_blink_arbiter;

  localparam int B = 4;
  localparam int G = 2;
  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [4*N-1:0] req_count;
  logic [N-1:0]   grant;
  logic [N-1:0]   ack;
  logic           busy;
  logic           LED;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [N-1:0] grant;
    int           led_cycles;
    int           latency;
  } exp_t;

  exp_t sb[$];

  led_blink_arbiter #(
    .BLINK_INTERVAL(B),
    .GAP_INTERVALS (G),
    .NUM_REQ       (N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_count(req_count),
    .grant    (grant),
    .ack      (ack),
    .busy     (busy),
    .LED      (LED)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model of one code: count blinks of B on / B off, then G*B gap;
  // ack is seen 2*B*count + G*B samples after grant is first seen.
  function automatic exp_t model(input logic [N-1:0] g, input int cnt);
    exp_t e;
    e.grant      = g;
    e.led_cycles = cnt * B;
    e.latency    = 2 * B * cnt + G * B;
    return e;
  endfunction

  // Waits for a grant, follows the code to its ack and compares against the
  // next scoreboard entry. Returns on the sample where ack is visible.
  task automatic collect(input string tag, input bit drop, input int exp_wait);
    exp_t         e;
    int           n;
    int           led_n;
    int           lat;
    bit           steady;
    logic [N-1:0] g;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    n = 0;
    while (grant === '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_grant"}, 32'(grant), 32'(e.grant));
    if (n >= 200) return;
    if (exp_wait >= 0) chk({tag, "_grant_wait"}, 32'(n), 32'(exp_wait));
    g      = grant;
    led_n  = 0;
    lat    = 0;
    steady = 1'b1;
    if (drop) begin
      req            = '0;
      req_count[3:0] = 4'd7;
    end
    while (ack === '0 && lat < 400) begin
      if (LED === 1'b1) led_n++;
      if (busy !== 1'b1 || grant !== g) steady = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_led_cycles"}, 32'(led_n), 32'(e.led_cycles));
    chk({tag, "_latency"}, 32'(lat), 32'(e.latency));
    chk({tag, "_busy_grant_steady"}, 32'(steady), 32'd1);
    chk({tag, "_ack"}, 32'(ack), 32'(e.grant));
    chk({tag, "_grant_cleared"}, 32'(grant), 32'd0);
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] rr_second;
    int           n;
    bit           quiet;

    rst       = 1'b1;
    req       = '0;
    req_count = '0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ack",   32'(ack),   32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_led",   32'(LED),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // req=1001 held, both counts 1; grant must wait out the ack cycle.
`ifdef BLINK_RR_EN
    rr_second = 4'b1000;
`else
    rr_second = 4'b0001;
`endif
    req_count = 16'h1001;
    req       = 4'b1001;
    sb.push_back(model(4'b0001, 1));
    sb.push_back(model(rr_second, 1));
    sb.push_back(model(4'b0001, 1));
    collect("rr1", 1'b0, 1);
    collect("rr2", 1'b0, 2);
    collect("rr3", 1'b0, 2);
    req = '0;
    repeat (3) @(negedge clk);

    // req[1] count 3.
    req_count = 16'h0030;
    req       = 4'b0010;
    sb.push_back(model(4'b0010, 3));
    collect("cnt3", 1'b0, 1);
    req = '0;
    repeat (3) @(negedge clk);

    // req[2] count 0: straight to gap, LED never lit.
    req_count = 16'h0000;
    req       = 4'b0100;
    sb.push_back(model(4'b0100, 0));
    collect("cnt0", 1'b0, 1);
    req = '0;
    repeat (3) @(negedge clk);

    // req[0] count 2, dropped and count changed to 7 right after grant.
    req_count = 16'h0002;
    req       = 4'b0001;
    sb.push_back(model(4'b0001, 2));
    collect("drop", 1'b1, 1);
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (grant !== '0) quiet = 1'b0;
    end
    chk("drop_no_regrant", 32'(quiet), 32'd1);

    // Reset during the 2nd ON phase of a count-5 code on req[3].
    req_count = 16'h5000;
    req       = 4'b1000;
    n = 0;
    while (grant === '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("abort_grant", 32'(grant), 32'h8);
    repeat (9) @(negedge clk);
    chk("abort_on2_led", 32'(LED), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_led",   32'(LED),   32'd0);
    chk("abort_grant0", 32'(grant), 32'd0);
    chk("abort_ack",   32'(ack),   32'd0);
    chk("abort_busy",  32'(busy),  32'd0);
    rst       = 1'b0;
    req       = 4'b0010;
    req_count = 16'h0010;
    sb.push_back(model(4'b0010, 1));
    collect("post_rst", 1'b0, 1);
    req = '0;
    repeat (3) @(negedge clk);

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_blink_arbiter.md
LED_BLINK_ARBITER -- requirements
Module: led_blink_arbiter

Interface
REQ-001 Parameter BLINK_INTERVAL, default 6000000, SHALL set the cycles per LED on-phase and per off-phase (0.5 s at 12 MHz).
REQ-002 Parameter GAP_INTERVALS, default 4, SHALL set the inter-code gap length, in units of BLINK_INTERVAL.
REQ-003 Parameter NUM_REQ, default 4, SHALL set the number of requesters (range 2..8).
REQ-004 Port clk, input, 1, SHALL be the single 12 MHz clock; all state updates on posedge clk.
REQ-005 Port rst, input, 1, SHALL be a synchronous, active-high reset.
REQ-006 Port req, input, NUM_REQ, SHALL carry per-requester blink-code requests; a requester holds its bit high until it receives ack.
REQ-007 Port req_count, input, 4*NUM_REQ, SHALL carry per-requester blink counts; slice i is [4i+3:4i], sampled only at grant.
REQ-008 Port grant, output, NUM_REQ, SHALL be one-hot for the requester being served, or zero when idle.
REQ-009 Port ack, output, NUM_REQ, SHALL pulse for one cycle on the bit of the requester whose code has finished.
REQ-010 Port busy, output, 1, SHALL be high whenever the state is not IDLE.
REQ-011 Port LED, output, 1, SHALL be the shared LED drive (1 = on).

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, ON, OFF, GAP.
REQ-013 In IDLE with ack low and req nonzero, the same edge SHALL select a winner (REQ-026), set grant, latch remaining <= req_count slice and clear the timer.
REQ-014 At that grant edge, a nonzero count SHALL move the FSM to ON with LED <= 1; a zero count SHALL move it to GAP with LED held at 0.
REQ-015 ON SHALL last exactly BLINK_INTERVAL cycles with LED = 1, then move to OFF with LED <= 0 and the timer cleared.
REQ-016 OFF SHALL last exactly BLINK_INTERVAL cycles, and remaining SHALL decrement by 1 on exit.
REQ-017 On OFF exit, the FSM SHALL go to ON if the decremented remaining is nonzero, otherwise to GAP.
REQ-018 GAP SHALL last exactly GAP_INTERVALS*BLINK_INTERVAL cycles with LED = 0.
REQ-019 On GAP exit, the FSM SHALL set state <= IDLE, grant <= 0 and ack[winner] <= 1 for exactly one cycle.
REQ-020 No grant SHALL be issued in a cycle where ack is high, which guarantees at least one idle cycle between codes.
REQ-021 A requester that drops req mid-sequence SHALL NOT abort the sequence; the code completes and ack still pulses.
REQ-022 req_count changes after grant SHALL be ignored.
REQ-023 The timer SHALL be wide enough for GAP_INTERVALS*BLINK_INTERVAL-1 and SHALL never wrap within a phase.
REQ-024 Total LED-high cycles per code SHALL equal count*BLINK_INTERVAL, for counts 0..15.

Reset
REQ-025 While rst is high, the block SHALL set state=IDLE, LED=0, grant=0, ack=0, busy=0, timer=0, remaining=0 and RR pointer=NUM_REQ-1; rst mid-sequence SHALL abort the code with no ack, and the block SHALL accept a grant on the first cycle after rst falls.

Configuration
REQ-026 With BLINK_RR_EN defined, arbitration SHALL be round-robin: the search starts at (last_winner+1) mod NUM_REQ, and the pointer updates at each grant.
REQ-027 Without BLINK_RR_EN, arbitration SHALL be fixed priority with the lowest index winning, and no pointer register SHALL exist.

Verification (BLINK_INTERVAL=4, GAP_INTERVALS=2, NUM_REQ=4)
REQ-028 req[1]=1, count 3 -> LED pattern 4 on/4 off x3, then 8 low; ack[1] pulses on cycle 33 after grant; busy high throughout.
REQ-029 req[2]=1, count 0 -> LED never high; GAP of 8 cycles; ack[2] pulses; grant=0100 during the gap.
REQ-030 req=1001 held continuously, counts 1 -> RR build: grants 0001, 1000, 0001 in turn; non-RR build: 0001 every time.
REQ-031 rst asserted in the 2nd ON phase of a count-5 code -> next cycle LED=0, grant=0, no ack; a new request is granted on the first cycle after rst falls.
REQ-032 req[0] dropped and req_count[0] changed to 7 after grant with count 2 -> exactly 2 blinks, then ack[0]; no re-grant while req=0.
REQ-033 ack cycle with req still high -> grant stays 0 that cycle and is reissued on the following edge.
